// File: rtl/chaining_scoreboard_pkg.sv
// chaining_pkg: shared definitions for the chaining hazard scoreboard.
//
// Holds the scoreboard geometry, the per-record state struct, the
// wrap-aware instruction age compare and the register window helpers.
//
// Configuration macro: CHAINING_WB_BYPASS_EN (used in chaining_record).
package chaining_pkg;

    localparam int RECORDS    = 4;
    localparam int READ_PORTS = 2;
    localparam int WB_PORTS   = 1;
    localparam int VREGS      = 32;
    localparam int VW         = $clog2(VREGS);
    localparam int ELEMS      = 64;
    localparam int OW         = $clog2(ELEMS);
    localparam int MASK_REGS  = 8;
    localparam int MRW        = $clog2(MASK_REGS);
    localparam int MW         = MASK_REGS * ELEMS;
    localparam int BIT_W      = $clog2(MW);
    localparam int INST_W     = 3;
    localparam int OCC_W      = $clog2(RECORDS) + 1;

    // One in-flight writer; a mask bit of 1 means that element has landed.
    typedef struct packed {
        logic              valid;
        logic              vdValid;
        logic [VW-1:0]     vd;
        logic [INST_W-1:0] instIndex;
        logic [MW-1:0]     elementMask;
    } record_t;

    // The MSB of the instruction index is a wrap bit, so a plain compare of
    // the low bits is flipped whenever exactly one side has wrapped.
    function automatic logic older(input logic [INST_W-1:0] rd,
                                   input logic [INST_W-1:0] rec);
        return (rd == rec) |
               ((rd[INST_W-2:0] < rec[INST_W-2:0]) ^ rd[INST_W-1] ^ rec[INST_W-1]);
    endfunction

    // Distance of register r above the record base, modulo VREGS.
    function automatic logic [VW-1:0] windowIndex(input logic [VW-1:0] r,
                                                  input logic [VW-1:0] base);
        return r - base;
    endfunction

    function automatic logic inWindow(input logic [VW-1:0] d);
        return d < VW'(MASK_REGS);
    endfunction

    // MASK_REGS and ELEMS are powers of two, so d*ELEMS+offset is a concat.
    function automatic logic [BIT_W-1:0] bitIndex(input logic [VW-1:0] d,
                                                  input logic [OW-1:0] offset);
        return {d[MRW-1:0], offset};
    endfunction

endpackage

// File: rtl/chaining_scoreboard_if.sv
// chaining_scoreboard_if: issue, write-back and read-check signals of the
// chaining scoreboard.
//
// master: issue stage / write-back path / operand arbiters (drives requests)
// slave : the scoreboard (drives alloc_ready, checkResult, occupancy, alloc_err)
interface chaining_scoreboard_if;
    import chaining_pkg::*;

    logic                           alloc_valid;
    logic                           alloc_ready;
    logic                           alloc_vd_valid;
    logic [VW-1:0]                  alloc_vd;
    logic [INST_W-1:0]              alloc_instIndex;
    logic [WB_PORTS-1:0]            wb_valid;
    logic [WB_PORTS*INST_W-1:0]     wb_instIndex;
    logic [WB_PORTS*VW-1:0]         wb_vd;
    logic [WB_PORTS*OW-1:0]         wb_offset;
    logic                           retire_valid;
    logic [INST_W-1:0]              retire_instIndex;
    logic [READ_PORTS*VW-1:0]       read_vs;
    logic [READ_PORTS*OW-1:0]       read_offset;
    logic [READ_PORTS*INST_W-1:0]   read_instructionIndex;
    logic [READ_PORTS-1:0]          checkResult;
    logic [OCC_W-1:0]               occupancy;
    logic                           alloc_err;

    modport master (
        output alloc_valid, alloc_vd_valid, alloc_vd, alloc_instIndex,
        output wb_valid, wb_instIndex, wb_vd, wb_offset,
        output retire_valid, retire_instIndex,
        output read_vs, read_offset, read_instructionIndex,
        input  alloc_ready, checkResult, occupancy, alloc_err
    );

    modport slave (
        input  alloc_valid, alloc_vd_valid, alloc_vd, alloc_instIndex,
        input  wb_valid, wb_instIndex, wb_vd, wb_offset,
        input  retire_valid, retire_instIndex,
        input  read_vs, read_offset, read_instructionIndex,
        output alloc_ready, checkResult, occupancy, alloc_err
    );

endinterface

// File: rtl/chaining_scoreboard_record.sv
// chaining_record: one scoreboard slot.
//
// Ports: clock/reset; allocEn + alloc fields load the slot; wb* are the
// element write-back ports; retire* frees the slot; read* are the check
// ports; valid/instIndex expose the slot for allocation and duplicate
// detection; blocked[p] flags a read-after-write hazard on read port p.
//
// CHAINING_WB_BYPASS_EN: when defined, this cycle's write-backs are ORed
// into the mask seen by the check ports.
module chaining_record
    import chaining_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          allocEn,
    input  logic                          allocVdValid,
    input  logic [VW-1:0]                 allocVd,
    input  logic [INST_W-1:0]             allocInst,
    input  logic [WB_PORTS-1:0]           wbValid,
    input  logic [WB_PORTS*INST_W-1:0]    wbInst,
    input  logic [WB_PORTS*VW-1:0]        wbVd,
    input  logic [WB_PORTS*OW-1:0]        wbOffset,
    input  logic                          retireValid,
    input  logic [INST_W-1:0]             retireInst,
    input  logic [READ_PORTS*VW-1:0]      readVs,
    input  logic [READ_PORTS*OW-1:0]      readOffset,
    input  logic [READ_PORTS*INST_W-1:0]  readInst,
    output logic                          valid,
    output logic [INST_W-1:0]             instIndex,
    output logic [READ_PORTS-1:0]         blocked
);

    record_t     rec;
    logic [MW-1:0] wbSet;
    logic [MW-1:0] checkMask;
    logic          retireHit;

    // Mask bits landing this cycle; only a live slot with a matching index
    // accepts them, so a write-back racing the allocation is dropped.
    always_comb begin
        wbSet = '0;
        for (int w = 0; w < WB_PORTS; w++) begin
            if (rec.valid && wbValid[w] &&
                wbInst[w*INST_W +: INST_W] == rec.instIndex &&
                inWindow(windowIndex(wbVd[w*VW +: VW], rec.vd))) begin
                wbSet[bitIndex(windowIndex(wbVd[w*VW +: VW], rec.vd),
                               wbOffset[w*OW +: OW])] = 1'b1;
            end
        end
    end

    assign retireHit = rec.valid && retireValid && (retireInst == rec.instIndex);

    // Retire takes priority over a same-cycle write-back to the same slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rec <= '0;
        end else if (allocEn) begin
            rec <= '{valid: 1'b1, vdValid: allocVdValid, vd: allocVd,
                     instIndex: allocInst, elementMask: '0};
        end else if (retireHit) begin
            rec.valid <= 1'b0;
        end else begin
            rec.elementMask <= rec.elementMask | wbSet;
        end
    end

`ifdef CHAINING_WB_BYPASS_EN
    assign checkMask = rec.elementMask | wbSet;
`else
    assign checkMask = rec.elementMask;
`endif

    // A reader waits only on a write from an older instruction that covers
    // the element and has not delivered it yet.
    always_comb begin
        blocked = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (rec.valid && rec.vdValid &&
                !older(readInst[p*INST_W +: INST_W], rec.instIndex) &&
                inWindow(windowIndex(readVs[p*VW +: VW], rec.vd)) &&
                !checkMask[bitIndex(windowIndex(readVs[p*VW +: VW], rec.vd),
                                    readOffset[p*OW +: OW])]) begin
                blocked[p] = 1'b1;
            end
        end
    end

    assign valid     = rec.valid;
    assign instIndex = rec.instIndex;

endmodule

// File: rtl/chaining_scoreboard.sv
// chaining_scoreboard: multi-record, multi-port chaining hazard scoreboard.
//
// Ports: clock (rising edge), reset (async, active high), bus (slave modport
// of chaining_scoreboard_if carrying allocate, write-back, retire and read
// check signals plus alloc_ready, checkResult, occupancy, alloc_err).
//
// CHAINING_WB_BYPASS_EN: forwards same-cycle write-backs into the checks.
module chaining_scoreboard
    import chaining_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    chaining_scoreboard_if.slave  bus
);

    logic [RECORDS-1:0]    recValid;
    logic [INST_W-1:0]     recInst    [RECORDS];
    logic [READ_PORTS-1:0] recBlocked [RECORDS];
    logic [RECORDS-1:0]    allocSel;
    logic [RECORDS-1:0]    instMatch;
    logic                  found;
    logic                  allocReady;
    logic                  dupHit;
    logic                  allocFire;
    logic                  allocErr;
    logic [OCC_W-1:0]      occ;
    logic [READ_PORTS-1:0] blockedAny;

    // Lowest free slot wins; a slot freed this cycle is not yet free here.
    always_comb begin
        allocSel = '0;
        found    = 1'b0;
        for (int r = 0; r < RECORDS; r++) begin
            if (!recValid[r] && !found) begin
                allocSel[r] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        instMatch = '0;
        for (int r = 0; r < RECORDS; r++) begin
            instMatch[r] = recValid[r] && (recInst[r] == bus.alloc_instIndex);
        end
    end

    assign allocReady = ~&recValid;
    assign dupHit     = |instMatch;
    assign allocFire  = bus.alloc_valid && allocReady && !dupHit;

    // Sticky until reset so software can see that an allocation was lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            allocErr <= 1'b0;
        end else if (bus.alloc_valid && allocReady && dupHit) begin
            allocErr <= 1'b1;
        end
    end

    for (genvar r = 0; r < RECORDS; r++) begin : gRecord
        chaining_record uRecord (
            .clock        (clock),
            .reset        (reset),
            .allocEn      (allocFire && allocSel[r]),
            .allocVdValid (bus.alloc_vd_valid),
            .allocVd      (bus.alloc_vd),
            .allocInst    (bus.alloc_instIndex),
            .wbValid      (bus.wb_valid),
            .wbInst       (bus.wb_instIndex),
            .wbVd         (bus.wb_vd),
            .wbOffset     (bus.wb_offset),
            .retireValid  (bus.retire_valid),
            .retireInst   (bus.retire_instIndex),
            .readVs       (bus.read_vs),
            .readOffset   (bus.read_offset),
            .readInst     (bus.read_instructionIndex),
            .valid        (recValid[r]),
            .instIndex    (recInst[r]),
            .blocked      (recBlocked[r])
        );
    end

    // Live record count and the OR of every slot's hazard flags.
    always_comb begin
        occ        = '0;
        blockedAny = '0;
        for (int r = 0; r < RECORDS; r++) begin
            occ        = occ + OCC_W'(recValid[r]);
            blockedAny = blockedAny | recBlocked[r];
        end
    end

    assign bus.alloc_ready = allocReady;
    assign bus.alloc_err   = allocErr;
    assign bus.occupancy   = occ;
    assign bus.checkResult = ~blockedAny;

endmodule

// File: tb/tb_chaining_scoreboard.sv
// tb_chaining_scoreboard: self-checking bench for chaining_scoreboard.
//
// Drives the scoreboard through its interface with directed vectors and
// compares against hand-computed expectations. Expectations for the
// same-cycle write-back check follow CHAINING_WB_BYPASS_EN.
module tb_chaining_scoreboard;
    import chaining_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    chaining_scoreboard_if bus ();

    chaining_scoreboard dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

`ifdef CHAINING_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct {
        logic [VW-1:0]     vs0;
        logic [OW-1:0]     off0;
        logic [INST_W-1:0] inst0;
        logic [VW-1:0]     vs1;
        logic [OW-1:0]     off1;
        logic [INST_W-1:0] inst1;
        logic [1:0]        expected;
    } readVec_t;

    readVec_t vecs [5];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic aV, input logic aVdV,
                                 input logic [VW-1:0] aVd, input logic [INST_W-1:0] aInst,
                                 input logic wV, input logic [INST_W-1:0] wInst,
                                 input logic [VW-1:0] wVd, input logic [OW-1:0] wOff,
                                 input logic rV, input logic [INST_W-1:0] rInst);
        bus.alloc_valid      = aV;
        bus.alloc_vd_valid   = aVdV;
        bus.alloc_vd         = aVd;
        bus.alloc_instIndex  = aInst;
        bus.wb_valid         = wV;
        bus.wb_instIndex     = wInst;
        bus.wb_vd            = wVd;
        bus.wb_offset        = wOff;
        bus.retire_valid     = rV;
        bus.retire_instIndex = rInst;
    endtask

    task automatic clearControls();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic setRead(input int p, input logic [VW-1:0] vs,
                           input logic [OW-1:0] off, input logic [INST_W-1:0] inst);
        bus.read_vs[p*VW +: VW]                       = vs;
        bus.read_offset[p*OW +: OW]                   = off;
        bus.read_instructionIndex[p*INST_W +: INST_W] = inst;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // record under test: inst=1, vd=8 (window v8..v15), nothing written
        vecs[0] = '{5'd9,  6'd5,  3'd2, 5'd9,  6'd5,  3'd0, 2'b10};
        vecs[1] = '{5'd9,  6'd5,  3'd1, 5'd16, 6'd5,  3'd2, 2'b11};
        vecs[2] = '{5'd15, 6'd63, 3'd2, 5'd7,  6'd0,  3'd2, 2'b10};
        vecs[3] = '{5'd8,  6'd0,  3'd2, 5'd8,  6'd0,  3'd3, 2'b00};
        vecs[4] = '{5'd12, 6'd10, 3'd5, 5'd12, 6'd10, 3'd4, 2'b01};

        clearControls();
        setRead(0, 0, 0, 0);
        setRead(1, 0, 0, 0);
        reset = 1'b1;
        #2;
        checkOutput("resetAllocReady", 32'(bus.alloc_ready), 1);
        checkOutput("resetOccupancy", 32'(bus.occupancy), 0);
        checkOutput("resetAllocErr", 32'(bus.alloc_err), 0);
        checkOutput("resetCheck", 32'(bus.checkResult), 2'b11);
        @(negedge clock);
        reset = 1'b0;
        step();

        applyStimulus(1, 1, 8, 1, 0, 0, 0, 0, 0, 0);
        step();
        clearControls();
        checkOutput("allocOccupancy", 32'(bus.occupancy), 1);

        for (int i = 0; i < 5; i++) begin
            setRead(0, vecs[i].vs0, vecs[i].off0, vecs[i].inst0);
            setRead(1, vecs[i].vs1, vecs[i].off1, vecs[i].inst1);
            #1;
            checkOutput($sformatf("vec%0d", i), 32'(bus.checkResult), 32'(vecs[i].expected));
        end

        // write-back of v9[5] observed in the same cycle and the next
        applyStimulus(0, 0, 0, 0, 1, 1, 9, 5, 0, 0);
        setRead(0, 9, 5, 2);
        setRead(1, 9, 6, 2);
        #1;
        checkOutput("sameCycleWb", 32'(bus.checkResult), 32'({1'b0, BYP}));
        step();
        clearControls();
        #1;
        checkOutput("afterWb", 32'(bus.checkResult), 2'b01);

        // v16 is just outside the window; it must not alias onto v8[7]
        applyStimulus(0, 0, 0, 0, 1, 1, 16, 7, 0, 0);
        step();
        clearControls();
        setRead(0, 8, 7, 2);
        setRead(1, 12, 10, 2);
        #1;
        checkOutput("outOfWindowWb", 32'(bus.checkResult), 2'b00);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step();
        clearControls();
        checkOutput("retireOccupancy", 32'(bus.occupancy), 0);
        checkOutput("retireCheck", 32'(bus.checkResult), 2'b11);

        // wrap: record inst=6 blocks reader 1 but not reader 5
        applyStimulus(1, 1, 0, 6, 0, 0, 0, 0, 0, 0);
        step();
        clearControls();
        setRead(0, 0, 0, 1);
        setRead(1, 0, 0, 5);
        #1;
        checkOutput("wrapCheck", 32'(bus.checkResult), 2'b10);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        step();
        clearControls();
        checkOutput("fullOccupancy", 32'(bus.occupancy), 4);
        checkOutput("fullAllocReady", 32'(bus.alloc_ready), 0);

        applyStimulus(1, 1, 20, 7, 0, 0, 0, 0, 0, 0);
        step();
        clearControls();
        checkOutput("fullAllocIgnored", 32'(bus.occupancy), 4);

        // retire inst 0 and allocate inst 7 together: slot not reusable yet
        applyStimulus(1, 1, 20, 7, 0, 0, 0, 0, 1, 0);
        step();
        clearControls();
        checkOutput("retireAllocOccupancy", 32'(bus.occupancy), 3);
        checkOutput("retireAllocReady", 32'(bus.alloc_ready), 1);

        applyStimulus(1, 1, 4, 2, 0, 0, 0, 0, 0, 0);
        step();
        clearControls();
        checkOutput("dupAllocErr", 32'(bus.alloc_err), 1);
        checkOutput("dupOccupancy", 32'(bus.occupancy), 3);

        // write-back racing its own allocation is dropped
        applyStimulus(1, 1, 20, 7, 1, 7, 20, 3, 0, 0);
        step();
        clearControls();
        setRead(0, 20, 3, 0);
        setRead(1, 0, 0, 1);
        #1;
        checkOutput("allocWbOccupancy", 32'(bus.occupancy), 4);
        checkOutput("allocWbDropped", 32'(bus.checkResult), 2'b00);

        // retire beats a same-cycle write-back: the slot is freed
        applyStimulus(0, 0, 0, 0, 1, 7, 20, 3, 1, 7);
        step();
        clearControls();
        #1;
        checkOutput("wbRetireOccupancy", 32'(bus.occupancy), 3);
        checkOutput("wbRetireCheck", 32'(bus.checkResult), 2'b01);

        // asynchronous reset between clock edges
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midResetOccupancy", 32'(bus.occupancy), 0);
        checkOutput("midResetAllocReady", 32'(bus.alloc_ready), 1);
        checkOutput("midResetAllocErr", 32'(bus.alloc_err), 0);
        checkOutput("midResetCheck", 32'(bus.checkResult), 2'b11);
        @(negedge clock);
        reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
